qif_spike_decoder: RTL

//  Receive side of the QIF neuron spike output: decodes a spike line into inter-spike

---
 rtl/qif_pkg.sv | 24 ++
 rtl/qif_sync_edge.sv | 46 ++++
 rtl/qif_spike_decoder.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/qif_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : qif_pkg                                                  |
// | Description : Shared widths, types and FSM encoding for the QIF spike  |
// |               decoder (host/readout side of the QIF neuron spike bit). |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package qif_pkg;

  localparam int unsigned C_ISI_W = 16;
  localparam int unsigned C_CNT_W = 8;

  typedef logic [C_ISI_W-1:0] isi_t;
  typedef logic [C_CNT_W-1:0] cnt_t;

  // IDLE: no reference spike yet. ARMED: a reference spike has been seen,
  // so the next event closes an interval.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } dec_state_t;

endpackage : qif_pkg
`default_nettype wire

// File: rtl/qif_sync_edge.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : qif_sync_edge                                            |
// | Description : Synchronises an asynchronous spike level, detects its    |
// |               rising edge and presents a one-cycle event, gated by ena.|
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
// Ports
//   clk      in  1  clock
//   rst_n    in  1  asynchronous active-low reset
//   ena      in  1  event gate; the chain keeps running while low
//   spike_i  in  1  raw spike level (asynchronous)
//   event_o  out 1  one-cycle rising-edge event
module qif_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic spike_i,
  output logic event_o
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;
  logic                   r_rise;

  // The delay flop and the rise register run regardless of ena, so an edge
  // that happened while disabled cannot surface later as a stale event.
  // The rise is registered, giving a fixed SYNC_STAGES+1 cycle input latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], spike_i};
      r_dly  <= r_sync[SYNC_STAGES-1];
      r_rise <= r_sync[SYNC_STAGES-1] & ~r_dly;
    end
  end

  assign event_o = r_rise & ena;

endmodule : qif_sync_edge
`default_nettype wire

// File: rtl/qif_spike_decoder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : qif_spike_decoder                                        |
// | Description : Decodes the QIF neuron spike line into inter-spike       |
// |               intervals (valid/ready register) and a windowed spike    |
// |               rate (one-cycle pulse per window).                       |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
// Ports
//   clk          in  1      clock
//   rst_n        in  1      asynchronous active-low reset
//   ena          in  1      count enable; low freezes counters, ignores edges
//   clear_i      in  1      synchronous soft clear (isi_o / rate_o hold)
//   spike_i      in  1      spike level, may be asynchronous
//   isi_o        out ISI_W  last captured interval in clk cycles (saturating)
//   isi_valid_o  out 1      isi_o holds an unconsumed value
//   isi_ready_i  in  1      consumer accepts isi_o
//   rate_o       out CNT_W  spike count of last completed window (saturating)
//   rate_valid_o out 1      one-cycle pulse when rate_o updates
//   overrun_o    out 1      sticky: an interval was dropped (output occupied)
module qif_spike_decoder
  import qif_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int ISI_W         = C_ISI_W,
  parameter int CNT_W         = C_CNT_W,
  parameter int WINDOW_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             clear_i,
  input  logic             spike_i,
  output logic [ISI_W-1:0] isi_o,
  output logic             isi_valid_o,
  input  logic             isi_ready_i,
  output logic [CNT_W-1:0] rate_o,
  output logic             rate_valid_o,
  output logic             overrun_o
);

  localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;

  localparam logic [ISI_W-1:0] c_isi_max  = {ISI_W{1'b1}};
  localparam logic [ISI_W-1:0] c_isi_one  = ISI_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
  localparam logic [WIN_W-1:0] c_win_last = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [WIN_W-1:0] c_win_one  = WIN_W'(1);

  logic             w_event;
  dec_state_t       r_state;
  dec_state_t       w_state_nxt;
  logic             w_armed;
  logic             w_emit;

  logic [ISI_W-1:0] r_isi_cnt;
  logic [ISI_W-1:0] r_isi;
  logic             r_isi_valid;
  logic             r_overrun;

  logic [WIN_W-1:0] r_win;
  logic [CNT_W-1:0] r_spk;
  logic [CNT_W-1:0] w_spk_sum;
  logic [CNT_W-1:0] r_rate;
  logic             r_rate_valid;

  qif_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .spike_i (spike_i),
    .event_o (w_event)
  );

  // ---------------- decoder FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear_i) begin
      w_state_nxt = IDLE;
    end else if ((r_state == IDLE) && w_event) begin
      w_state_nxt = ARMED;
    end
  end

  always_comb begin
    w_armed = (r_state == ARMED);
  end

  // An interval is only reported once a reference spike exists; clear
  // discards an event arriving in the same cycle.
  assign w_emit = w_event & w_armed & ~clear_i;

  // ---------------- ISI counter ----------------
  // Restarts at 1 on every event so that events N enabled cycles apart
  // read back N as the pre-update value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_isi_cnt <= '0;
    end else if (clear_i) begin
      r_isi_cnt <= '0;
    end else if (w_event) begin
      r_isi_cnt <= c_isi_one;
    end else if (ena && (r_isi_cnt != c_isi_max)) begin
      r_isi_cnt <= r_isi_cnt + c_isi_one;
    end
  end

  // ---------------- ISI output register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_isi       <= '0;
      r_isi_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (clear_i) begin
      r_isi_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (w_emit) begin
      if (!r_isi_valid || isi_ready_i) begin
        // Free slot, or the old value is consumed this very cycle.
        r_isi       <= r_isi_cnt;
        r_isi_valid <= 1'b1;
      end else begin
        r_overrun   <= 1'b1;
      end
    end else if (r_isi_valid && isi_ready_i) begin
      r_isi_valid <= 1'b0;
    end
  end

  // ---------------- rate window ----------------
  always_comb begin
    w_spk_sum = r_spk;
    if (w_event && (r_spk != c_cnt_max)) begin
      w_spk_sum = r_spk + c_cnt_one;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win        <= '0;
      r_spk        <= '0;
      r_rate       <= '0;
      r_rate_valid <= 1'b0;
    end else if (clear_i) begin
      r_win        <= '0;
      r_spk        <= '0;
      r_rate_valid <= 1'b0;
    end else begin
      r_rate_valid <= 1'b0;
      if (ena) begin
        if (r_win == c_win_last) begin
          // The last window cycle's own event is included in the report.
          r_rate       <= w_spk_sum;
          r_rate_valid <= 1'b1;
          r_spk        <= '0;
          r_win        <= '0;
        end else begin
          r_spk <= w_spk_sum;
          r_win <= r_win + c_win_one;
        end
      end
    end
  end

  assign isi_o        = r_isi;
  assign isi_valid_o  = r_isi_valid;
  assign rate_o       = r_rate;
  assign rate_valid_o = r_rate_valid;
  assign overrun_o    = r_overrun;

endmodule : qif_spike_decoder
`default_nettype wire
